meep_axi_calib_gate: RTL and testbench

//  Parametrised AXI4 traffic gate between the OpenPiton chipset AXI masters (mem/sram/eth) and their slaves.

---
 rtl/meep_axi_gate_pkg.sv | 16 +
 rtl/meep_outstanding_ctr.sv | 32 +++
 rtl/meep_axi_calib_gate.sv | 206 ++++++++++++++++++++
 tb/tb_meep_axi_calib_gate.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meep_axi_gate_pkg.sv
// Shared types and helpers for the AXI calibration/isolation gate.
package meep_axi_gate_pkg;

  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    OPEN     = 2'd1,
    DRAIN    = 2'd2,
    ISOLATED = 2'd3
  } state_t;

  // Bits needed to hold 0..max_out inclusive.
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/meep_outstanding_ctr.sv
// Saturating up/down counter tracking outstanding bursts or write credits.
module meep_outstanding_ctr
  import meep_axi_gate_pkg::*;
#(
  parameter  int MAX_W = 8,
  localparam int CNT_W = cnt_w(MAX_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty,
  output logic             underflow
);

  assign full      = (cnt == CNT_W'(MAX_W));
  assign empty     = (cnt == '0);
  assign underflow = dec && !inc && empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && !empty) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/meep_axi_calib_gate.sv
// AXI4 traffic gate: holds requests until the slave is ready, caps outstanding
// bursts per direction and drains cleanly before isolation for hot reset.
//
// state    | meaning
// WAIT_RDY | slave not usable yet, AW/AR closed
// OPEN     | traffic flows, subject to outstanding caps
// DRAIN    | no new AW/AR; in-flight W/B/R complete
// ISOLATED | drained and closed until isolate request drops
module meep_axi_calib_gate
  import meep_axi_gate_pkg::*;
#(
  parameter  int ID_W    = 6,
  parameter  int ADDR_W  = 64,
  parameter  int DATA_W  = 256,
  parameter  int USER_W  = 11,
  parameter  int MAX_OUT = 8,
  localparam int STRB_W  = DATA_W / 8
) (
  input  logic              chipset_clk,
  input  logic              chipset_rst,
  input  logic              slave_ready_i,
  input  logic              isolate_req_i,
  output logic              isolated_o,
  output logic              busy_o,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic [USER_W-1:0] s_axi_awuser,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0] s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic [USER_W-1:0] s_axi_wuser,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic [USER_W-1:0] s_axi_aruser,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic [USER_W-1:0] s_axi_buser,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic [USER_W-1:0] s_axi_ruser,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [ID_W-1:0]   m_axi_awid,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic [USER_W-1:0] m_axi_awuser,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic [USER_W-1:0] m_axi_wuser,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [USER_W-1:0] m_axi_aruser,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [ID_W-1:0]   m_axi_bid,
  input  logic [1:0]        m_axi_bresp,
  input  logic [USER_W-1:0] m_axi_buser,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic [USER_W-1:0] m_axi_ruser,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int CNT_W = cnt_w(MAX_OUT);

  state_t           state;
  logic [CNT_W-1:0] wr_cnt, rd_cnt, wc_cnt;
  logic             wr_full, rd_full, wc_full;
  logic             wr_empty, rd_empty, wc_empty;
  logic             wr_uf, rd_uf, wc_uf, err_underflow;
  logic             aw_open, ar_open, w_open;
  logic             aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;

  assign m_axi_awid    = s_axi_awid;
  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst;
  assign m_axi_awuser  = s_axi_awuser;
  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;
  assign m_axi_wuser   = s_axi_wuser;
  assign m_axi_arid    = s_axi_arid;
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;
  assign m_axi_aruser  = s_axi_aruser;

  assign s_axi_bid    = m_axi_bid;
  assign s_axi_bresp  = m_axi_bresp;
  assign s_axi_buser  = m_axi_buser;
  assign s_axi_bvalid = m_axi_bvalid;
  assign m_axi_bready = s_axi_bready;
  assign s_axi_rid    = m_axi_rid;
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_rlast  = m_axi_rlast;
  assign s_axi_ruser  = m_axi_ruser;
  assign s_axi_rvalid = m_axi_rvalid;
  assign m_axi_rready = s_axi_rready;

  assign b_hs      = m_axi_bvalid && s_axi_bready;
  assign r_last_hs = m_axi_rvalid && s_axi_rready && m_axi_rlast;

  // A completing response frees its slot in the same cycle; a saturated
  // write-credit counter also holds AW so credits can never be lost.
  assign aw_open = (state == OPEN) && (!wr_full || b_hs) && !wc_full;
  assign ar_open = (state == OPEN) && (!rd_full || r_last_hs);

  assign m_axi_awvalid = s_axi_awvalid && aw_open;
  assign s_axi_awready = m_axi_awready && aw_open;
  assign m_axi_arvalid = s_axi_arvalid && ar_open;
  assign s_axi_arready = m_axi_arready && ar_open;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // W follows only an accepted AW, independent of FSM state.
  assign w_open       = !wc_empty || aw_hs;
  assign m_axi_wvalid = s_axi_wvalid && w_open;
  assign s_axi_wready = m_axi_wready && w_open;
  assign w_last_hs    = s_axi_wvalid && s_axi_wready && s_axi_wlast;

  meep_outstanding_ctr #(.MAX_W(MAX_OUT)) u_wr_cnt (
    .clk(chipset_clk), .rst(chipset_rst), .inc(aw_hs), .dec(b_hs),
    .cnt(wr_cnt), .full(wr_full), .empty(wr_empty), .underflow(wr_uf)
  );

  meep_outstanding_ctr #(.MAX_W(MAX_OUT)) u_rd_cnt (
    .clk(chipset_clk), .rst(chipset_rst), .inc(ar_hs), .dec(r_last_hs),
    .cnt(rd_cnt), .full(rd_full), .empty(rd_empty), .underflow(rd_uf)
  );

  meep_outstanding_ctr #(.MAX_W(MAX_OUT)) u_w_credit (
    .clk(chipset_clk), .rst(chipset_rst), .inc(aw_hs), .dec(w_last_hs),
    .cnt(wc_cnt), .full(wc_full), .empty(wc_empty), .underflow(wc_uf)
  );

  assign err_underflow = wr_uf || rd_uf || wc_uf;

  always_ff @(posedge chipset_clk or posedge chipset_rst) begin
    if (chipset_rst) begin
      state      <= WAIT_RDY;
      isolated_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      busy_o     <= !(wr_empty && rd_empty);
      isolated_o <= 1'b0;
      case (state)
        WAIT_RDY: if (slave_ready_i && !isolate_req_i) state <= OPEN;
        OPEN: begin
          if (isolate_req_i)       state <= DRAIN;
          else if (!slave_ready_i) state <= WAIT_RDY;
        end
        DRAIN: begin
          if ((wr_cnt | rd_cnt | wc_cnt) == '0) begin
            state      <= ISOLATED;
            isolated_o <= 1'b1;
          end
        end
        ISOLATED: begin
          if (!isolate_req_i) state <= WAIT_RDY;
          else                isolated_o <= 1'b1;
        end
        default: state <= WAIT_RDY;
      endcase
    end
  end

  a_no_underflow: assert property (@(posedge chipset_clk) disable iff (chipset_rst)
                                    !err_underflow);

endmodule

// File: tb/tb_meep_axi_calib_gate.sv
// Scoreboard bench for meep_axi_calib_gate: directed stimulus pushes expected
// forwarded requests, a negedge monitor pops and compares downstream handshakes.
module tb_meep_axi_calib_gate;
  localparam int ID_W = 6, ADDR_W = 32, DATA_W = 64, USER_W = 11, MAX_OUT = 4;
  localparam int STRB_W = DATA_W / 8;

  logic chipset_clk = 1'b0;
  logic chipset_rst = 1'b1;
  always #5 chipset_clk = ~chipset_clk;

  logic slave_ready_i, isolate_req_i, isolated_o, busy_o;
  logic [ID_W-1:0]   s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [ADDR_W-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]        s_axi_awlen, s_axi_arlen;
  logic [2:0]        s_axi_awsize, s_axi_arsize;
  logic [1:0]        s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic [USER_W-1:0] s_axi_awuser, s_axi_wuser, s_axi_aruser, s_axi_buser, s_axi_ruser;
  logic [DATA_W-1:0] s_axi_wdata, s_axi_rdata;
  logic [STRB_W-1:0] s_axi_wstrb;
  logic s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic s_axi_arvalid, s_axi_arready, s_axi_bvalid, s_axi_bready;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [ID_W-1:0]   m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]        m_axi_awlen, m_axi_arlen;
  logic [2:0]        m_axi_awsize, m_axi_arsize;
  logic [1:0]        m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic [USER_W-1:0] m_axi_awuser, m_axi_wuser, m_axi_aruser, m_axi_buser, m_axi_ruser;
  logic [DATA_W-1:0] m_axi_wdata, m_axi_rdata;
  logic [STRB_W-1:0] m_axi_wstrb;
  logic m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic m_axi_arvalid, m_axi_arready, m_axi_bvalid, m_axi_bready;
  logic m_axi_rlast, m_axi_rvalid, m_axi_rready;

  meep_axi_calib_gate #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .USER_W(USER_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .chipset_clk(chipset_clk), .chipset_rst(chipset_rst),
    .slave_ready_i(slave_ready_i), .isolate_req_i(isolate_req_i),
    .isolated_o(isolated_o), .busy_o(busy_o),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awuser(s_axi_awuser),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wuser(s_axi_wuser), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_aruser(s_axi_aruser),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awuser(m_axi_awuser),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wuser(m_axi_wuser), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_aruser(m_axi_aruser),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_buser(m_axi_buser),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int total = 0;
  int bad   = 0;
  logic [ADDR_W-1:0] aw_q[$];
  logic [ADDR_W-1:0] ar_q[$];
  logic [DATA_W-1:0] w_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge chipset_clk);
    #1;
  endtask

  // Monitor: every downstream handshake must match the next expected entry.
  always @(negedge chipset_clk) begin
    if (!chipset_rst) begin
      if (m_axi_awvalid && m_axi_awready) begin
        if (aw_q.size() == 0) begin
          total++; bad++;
          $display("FAIL aw_unexpected: got addr %0h expected none", m_axi_awaddr);
        end else check("aw_fwd", 64'(m_axi_awaddr), 64'(aw_q.pop_front()));
      end
      if (m_axi_arvalid && m_axi_arready) begin
        if (ar_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ar_unexpected: got addr %0h expected none", m_axi_araddr);
        end else check("ar_fwd", 64'(m_axi_araddr), 64'(ar_q.pop_front()));
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (w_q.size() == 0) begin
          total++; bad++;
          $display("FAIL w_unexpected: got data %0h expected none", m_axi_wdata);
        end else check("w_fwd", 64'(m_axi_wdata), 64'(w_q.pop_front()));
      end
    end
  end

  task automatic issue_aw(input logic [ADDR_W-1:0] a, input logic [7:0] len);
    s_axi_awaddr = a; s_axi_awlen = len; s_axi_awvalid = 1'b1;
    aw_q.push_back(a);
    tick();
    s_axi_awvalid = 1'b0;
  endtask

  task automatic issue_ar(input logic [ADDR_W-1:0] a);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    ar_q.push_back(a);
    tick();
    s_axi_arvalid = 1'b0;
  endtask

  task automatic issue_w(input logic [DATA_W-1:0] d, input logic last);
    s_axi_wdata = d; s_axi_wlast = last; s_axi_wvalid = 1'b1;
    w_q.push_back(d);
    tick();
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask

  task automatic send_b(input logic [ID_W-1:0] id);
    m_axi_bid = id; m_axi_bvalid = 1'b1;
    @(negedge chipset_clk);
    check("b_pass", 64'({s_axi_bvalid, s_axi_bid}), 64'({1'b1, id}));
    tick();
    m_axi_bvalid = 1'b0;
  endtask

  task automatic send_r(input logic [DATA_W-1:0] d);
    m_axi_rdata = d; m_axi_rlast = 1'b1; m_axi_rvalid = 1'b1;
    @(negedge chipset_clk);
    check("r_pass", 64'(s_axi_rdata), 64'(d));
    tick();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int viol;
    int waited;
    slave_ready_i = 0; isolate_req_i = 0;
    s_axi_awid = 6'd1; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd3;
    s_axi_awburst = 2'd1; s_axi_awuser = '0; s_axi_awvalid = 0;
    s_axi_wdata = '0; s_axi_wstrb = '1; s_axi_wlast = 0; s_axi_wuser = '0; s_axi_wvalid = 0;
    s_axi_arid = 6'd2; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd3;
    s_axi_arburst = 2'd1; s_axi_aruser = '0; s_axi_arvalid = 0;
    s_axi_bready = 1; s_axi_rready = 1;
    m_axi_awready = 1; m_axi_wready = 1; m_axi_arready = 1;
    m_axi_bid = '0; m_axi_bresp = '0; m_axi_buser = '0; m_axi_bvalid = 0;
    m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
    m_axi_ruser = '0; m_axi_rvalid = 0;

    repeat (3) @(posedge chipset_clk);
    @(negedge chipset_clk);
    check("rst_isolated", 64'(isolated_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_ready", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'(0));
    #1 chipset_rst = 0;
    tick();

    // 1: closed while slave not ready, opens one cycle after ready rises
    s_axi_awaddr = 32'h1000; s_axi_awvalid = 1;
    s_axi_araddr = 32'h2000; s_axi_arvalid = 1;
    viol = 0;
    repeat (50) begin
      @(negedge chipset_clk);
      if (m_axi_awvalid || m_axi_arvalid || s_axi_awready || s_axi_arready) viol++;
      tick();
    end
    check("t1_gated_cycles", 64'(viol), 64'(0));
    slave_ready_i = 1;
    @(negedge chipset_clk);
    check("t1_closed_in_ready_cycle", 64'({m_axi_awvalid, m_axi_arvalid}), 64'(0));
    tick();
    aw_q.push_back(32'h1000);
    ar_q.push_back(32'h2000);
    @(negedge chipset_clk);
    check("t1_open_ready", 64'({s_axi_awready, s_axi_arready}), 64'(3));
    tick();
    s_axi_awvalid = 0; s_axi_arvalid = 0;
    issue_w(64'hA1, 1'b1);
    send_b(6'd1);
    send_r(64'hD1);
    tick();
    @(negedge chipset_clk);
    check("t1_idle_busy", 64'(busy_o), 64'(0));
    tick();

    // 2: read cap of MAX_OUT, freed slot reused in the same cycle
    for (int i = 0; i < 4; i++) issue_ar(32'h3000 + 32'(i));
    @(negedge chipset_clk);
    check("t2_rd_cnt_full", 64'(dut.u_rd_cnt.cnt), 64'(4));
    check("t2_busy", 64'(busy_o), 64'(1));
    tick();
    s_axi_araddr = 32'h3004; s_axi_arvalid = 1;
    viol = 0;
    repeat (5) begin
      @(negedge chipset_clk);
      if (s_axi_arready || m_axi_arvalid) viol++;
      tick();
    end
    check("t2_ar_stalled", 64'(viol), 64'(0));
    m_axi_rvalid = 1; m_axi_rlast = 1; m_axi_rdata = 64'hD2;
    ar_q.push_back(32'h3004);
    @(negedge chipset_clk);
    check("t2_ar_same_cycle", 64'(s_axi_arready), 64'(1));
    tick();
    m_axi_rvalid = 0; m_axi_rlast = 0;
    s_axi_araddr = 32'h3005;
    viol = 0;
    repeat (3) begin
      @(negedge chipset_clk);
      if (s_axi_arready || m_axi_arvalid) viol++;
      tick();
    end
    check("t2_ar_stalled_again", 64'(viol), 64'(0));
    s_axi_arvalid = 0;
    @(negedge chipset_clk);
    check("t2_rd_cnt_held", 64'(dut.u_rd_cnt.cnt), 64'(4));
    tick();
    for (int i = 0; i < 4; i++) send_r(64'hE0 + 64'(i));
    @(negedge chipset_clk);
    check("t2_rd_cnt_empty", 64'(dut.u_rd_cnt.cnt), 64'(0));
    tick();

    // 3: W held until its AW, credit consumed by last beat
    s_axi_wdata = 64'hB0; s_axi_wlast = 0; s_axi_wvalid = 1;
    viol = 0;
    repeat (10) begin
      @(negedge chipset_clk);
      if (m_axi_wvalid || s_axi_wready) viol++;
      tick();
    end
    check("t3_w_held", 64'(viol), 64'(0));
    s_axi_awaddr = 32'h4000; s_axi_awlen = 8'd3; s_axi_awvalid = 1;
    aw_q.push_back(32'h4000);
    w_q.push_back(64'hB0);
    @(negedge chipset_clk);
    check("t3_w_with_aw", 64'(s_axi_wready), 64'(1));
    tick();
    s_axi_awvalid = 0;
    for (int i = 1; i < 4; i++) begin
      s_axi_wdata = 64'hB0 + 64'(i); s_axi_wlast = (i == 3);
      w_q.push_back(s_axi_wdata);
      @(negedge chipset_clk);
      check("t3_credit_mid", 64'(dut.u_w_credit.cnt), 64'(1));
      tick();
    end
    s_axi_wdata = 64'hBF; s_axi_wlast = 0;
    viol = 0;
    repeat (3) begin
      @(negedge chipset_clk);
      if (m_axi_wvalid || s_axi_wready) viol++;
      tick();
    end
    check("t3_credit_zero", 64'(dut.u_w_credit.cnt), 64'(0));
    check("t3_extra_w_held", 64'(viol), 64'(0));
    s_axi_wvalid = 0;
    send_b(6'd1);

    // 5: simultaneous AW and B handshakes leave wr_cnt unchanged
    s_axi_awlen = 8'd0;
    for (int i = 0; i < 3; i++) issue_aw(32'h5000 + 32'(i), 8'd0);
    for (int i = 0; i < 3; i++) issue_w(64'hC0 + 64'(i), 1'b1);
    s_axi_awaddr = 32'h5003; s_axi_awvalid = 1; m_axi_bvalid = 1;
    aw_q.push_back(32'h5003);
    @(negedge chipset_clk);
    check("t5_aw_accepted", 64'(s_axi_awready), 64'(1));
    tick();
    s_axi_awvalid = 0; m_axi_bvalid = 0;
    @(negedge chipset_clk);
    check("t5_wr_cnt_stays", 64'(dut.u_wr_cnt.cnt), 64'(3));
    tick();
    issue_w(64'hC3, 1'b1);
    for (int i = 0; i < 3; i++) send_b(6'd1);
    @(negedge chipset_clk);
    check("t5_wr_cnt_drained", 64'(dut.u_wr_cnt.cnt), 64'(0));
    tick();

    // 4: isolate with 2 writes and 3 reads outstanding
    issue_aw(32'h6000, 8'd0);
    issue_aw(32'h6001, 8'd0);
    issue_w(64'hF0, 1'b1);
    issue_w(64'hF1, 1'b1);
    for (int i = 0; i < 3; i++) issue_ar(32'h6010 + 32'(i));
    isolate_req_i = 1;
    tick();
    s_axi_awaddr = 32'h6100; s_axi_awvalid = 1;
    s_axi_araddr = 32'h6200; s_axi_arvalid = 1;
    viol = 0;
    repeat (4) begin
      @(negedge chipset_clk);
      if (m_axi_awvalid || m_axi_arvalid || s_axi_awready || s_axi_arready || isolated_o) viol++;
      tick();
    end
    check("t4_drain_blocked", 64'(viol), 64'(0));
    s_axi_awvalid = 0; s_axi_arvalid = 0;
    send_b(6'd1);
    send_b(6'd1);
    send_r(64'h11);
    send_r(64'h12);
    m_axi_rvalid = 1; m_axi_rlast = 1; m_axi_rdata = 64'h13;
    @(negedge chipset_clk);
    check("t4_not_isolated_yet", 64'(isolated_o), 64'(0));
    tick();
    m_axi_rvalid = 0; m_axi_rlast = 0;
    waited = 0;
    @(negedge chipset_clk);
    while (isolated_o !== 1'b1 && waited < 3) begin
      tick();
      @(negedge chipset_clk);
      waited++;
    end
    check("t4_isolated", 64'(isolated_o), 64'(1));
    tick();
    isolate_req_i = 0;
    tick();
    @(negedge chipset_clk);
    check("t4_released", 64'(isolated_o), 64'(0));
    tick();
    s_axi_araddr = 32'h6300; s_axi_arvalid = 1;
    ar_q.push_back(32'h6300);
    @(negedge chipset_clk);
    check("t4_reopened", 64'(s_axi_arready), 64'(1));
    tick();
    s_axi_arvalid = 0;
    send_r(64'h14);

    // 6: async reset mid-burst
    issue_aw(32'h7000, 8'd1);
    issue_w(64'hD0, 1'b0);
    @(negedge chipset_clk);
    check("t6_credit_one", 64'(dut.u_w_credit.cnt), 64'(1));
    tick();
    s_axi_wdata = 64'hD1; s_axi_wlast = 1; s_axi_wvalid = 1;
    s_axi_awaddr = 32'h7100; s_axi_awvalid = 1;
    #1;
    check("t6_pre_wready", 64'({s_axi_wready, s_axi_awready}), 64'(3));
    #1 chipset_rst = 1;
    #1;
    check("t6_readies_low", 64'({s_axi_wready, s_axi_awready, m_axi_wvalid, m_axi_awvalid}), 64'(0));
    check("t6_counters", 64'({dut.u_wr_cnt.cnt, dut.u_rd_cnt.cnt, dut.u_w_credit.cnt}), 64'(0));
    check("t6_status", 64'({isolated_o, busy_o}), 64'(0));
    s_axi_wvalid = 0; s_axi_wlast = 0; s_axi_awvalid = 0;
    repeat (2) @(posedge chipset_clk);
    #1 chipset_rst = 0;
    tick();
    @(negedge chipset_clk);
    check("t6_post_busy", 64'(busy_o), 64'(0));

    check("aw_q_empty", 64'(aw_q.size()), 64'(0));
    check("ar_q_empty", 64'(ar_q.size()), 64'(0));
    check("w_q_empty", 64'(w_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
